// File: rtl/branch_predictor_if.sv
// Fetch-lookup and resolve-update signal bundle for the branch predictor.
interface branch_predictor_if #(
   parameter int WORD_LEN = 32,
   parameter int CNT_BITS = 16
);
   logic [WORD_LEN-1:0] fetchPC;
   logic                predTaken;
   logic                resolveValid;
   logic                resolveIsJump;
   logic [WORD_LEN-1:0] resolvePC;
   logic                resolvePredTaken;
   logic                brCond;
   logic                mispredict;
   logic [CNT_BITS-1:0] branchCount;
   logic [CNT_BITS-1:0] mispredCount;

   modport master (
      output fetchPC, resolveValid, resolveIsJump,
      output resolvePC, resolvePredTaken, brCond,
      input  predTaken, mispredict, branchCount, mispredCount
   );

   modport slave (
      input  fetchPC, resolveValid, resolveIsJump,
      input  resolvePC, resolvePredTaken, brCond,
      output predTaken, mispredict, branchCount, mispredCount
   );
endinterface

// File: rtl/branch_predictor.sv
// Two-bit saturating-counter branch history table with mispredict flag.
// Define BP_BYPASS_EN to forward a same-index update into the fetch lookup.
module branch_predictor #(
   parameter int WORD_LEN = 32,
   parameter int IDX_BITS = 4,
   parameter int CNT_BITS = 16
) (
   input logic              clk,
   input logic              rst,
   branch_predictor_if.slave bp
);
   localparam int ENTRIES = 2 ** IDX_BITS;

   logic [1:0]          cnt_tbl [ENTRIES];
   logic [CNT_BITS-1:0] br_cnt;
   logic [CNT_BITS-1:0] mis_cnt;

   logic [IDX_BITS-1:0] fetch_idx;
   logic [IDX_BITS-1:0] resolve_idx;
   logic [1:0]          cur_cnt;
   logic [1:0]          nxt_cnt;
   logic                upd;
   logic                mis;

   assign fetch_idx   = bp.fetchPC[IDX_BITS+1:2];
   assign resolve_idx = bp.resolvePC[IDX_BITS+1:2];
   assign upd         = bp.resolveValid & ~bp.resolveIsJump;
   assign mis         = bp.resolveValid
                      & (bp.brCond != bp.resolvePredTaken);
   assign cur_cnt     = cnt_tbl[resolve_idx];

   always_comb begin
      nxt_cnt = cur_cnt;
      if (bp.brCond) begin
         if (cur_cnt != 2'd3) nxt_cnt = cur_cnt + 2'd1;
      end else begin
         if (cur_cnt != 2'd0) nxt_cnt = cur_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) cnt_tbl[i] <= 2'd1;
         br_cnt  <= '0;
         mis_cnt <= '0;
      end else if (upd) begin
         cnt_tbl[resolve_idx] <= nxt_cnt;
         br_cnt               <= br_cnt + 1'b1;
         if (mis) mis_cnt <= mis_cnt + 1'b1;
      end
   end

`ifdef BP_BYPASS_EN
   always_comb begin
      bp.predTaken = cnt_tbl[fetch_idx][1];
      if (upd && (fetch_idx == resolve_idx)) bp.predTaken = nxt_cnt[1];
   end
`else
   assign bp.predTaken = cnt_tbl[fetch_idx][1];
`endif

   assign bp.mispredict   = mis;
   assign bp.branchCount  = br_cnt;
   assign bp.mispredCount = mis_cnt;

   // Bits outside the index field carry no information for the table.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bp.fetchPC[WORD_LEN-1:IDX_BITS+2],
                             bp.fetchPC[1:0],
                             bp.resolvePC[WORD_LEN-1:IDX_BITS+2],
                             bp.resolvePC[1:0]};
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   branch_predictor_if #(.WORD_LEN(32), .CNT_BITS(16)) bp ();

   branch_predictor #(
      .WORD_LEN(32), .IDX_BITS(4), .CNT_BITS(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bp (bp.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic jump,
                          input logic pt, input logic cond);
      bp.resolveValid     = 1'b1;
      bp.resolveIsJump    = jump;
      bp.resolvePC        = pc;
      bp.resolvePredTaken = pt;
      bp.brCond           = cond;
   endtask

   task automatic idle();
      bp.resolveValid     = 1'b0;
      bp.resolveIsJump    = 1'b0;
      bp.resolvePC        = '0;
      bp.resolvePredTaken = 1'b0;
      bp.brCond           = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      bp.fetchPC = '0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bp.fetchPC = 32'(i * 4);
         #1;
         checks++;
         if (bp.predTaken !== 1'b0) begin
            errors++;
            $display("FAIL reset_pred pc=%h got=%b exp=0", bp.fetchPC, bp.predTaken);
         end
      end
      checks++;
      if (bp.branchCount !== 16'd0 || bp.mispredCount !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bp.branchCount, bp.mispredCount);
      end
      checks++;
      if (bp.mispredict !== 1'b0) begin
         errors++;
         $display("FAIL idle_mispredict got=%b exp=0", bp.mispredict);
      end
   endtask

   task automatic test_train();
      for (int k = 0; k < 2; k++) begin
         resolve(32'h08, 1'b0, 1'b0, 1'b1);
         #1;
         checks++;
         if (bp.mispredict !== 1'b1) begin
            errors++;
            $display("FAIL train_mis%0d got=%b exp=1", k, bp.mispredict);
         end
         step();
      end
      idle();
      bp.fetchPC = 32'h08;
      #1;
      checks++;
      if (bp.predTaken !== 1'b1) begin
         errors++;
         $display("FAIL train_pred got=%b exp=1", bp.predTaken);
      end
      checks++;
      if (bp.branchCount !== 16'd2 || bp.mispredCount !== 16'd2) begin
         errors++;
         $display("FAIL train_cnt got=%0d/%0d exp=2/2", bp.branchCount, bp.mispredCount);
      end
   endtask

   task automatic test_saturate();
      logic exp_pred [4];
      exp_pred[0] = 1'b1;
      exp_pred[1] = 1'b0;
      exp_pred[2] = 1'b0;
      exp_pred[3] = 1'b0;
      bp.fetchPC = 32'h08;
      resolve(32'h08, 1'b0, 1'b1, 1'b1);
      #1;
      checks++;
      if (bp.mispredict !== 1'b0) begin
         errors++;
         $display("FAIL sat_hi_mis got=%b exp=0", bp.mispredict);
      end
      step();
      for (int k = 0; k < 4; k++) begin
         resolve(32'h08, 1'b0, 1'b0, 1'b0);
         step();
         idle();
         #1;
         checks++;
         if (bp.predTaken !== exp_pred[k]) begin
            errors++;
            $display("FAIL sat_nt%0d got=%b exp=%b", k, bp.predTaken, exp_pred[k]);
         end
      end
      // From 0 a single taken lands on 1, still predicting not-taken.
      resolve(32'h08, 1'b0, 1'b0, 1'b1);
      step();
      idle();
      #1;
      checks++;
      if (bp.predTaken !== 1'b0) begin
         errors++;
         $display("FAIL sat_lo got=%b exp=0", bp.predTaken);
      end
      checks++;
      if (bp.branchCount !== 16'd8 || bp.mispredCount !== 16'd3) begin
         errors++;
         $display("FAIL sat_cnt got=%0d/%0d exp=8/3", bp.branchCount, bp.mispredCount);
      end
   endtask

   task automatic test_jump();
      bp.fetchPC = 32'h04;
      resolve(32'h04, 1'b1, 1'b0, 1'b1);
      #1;
      checks++;
      if (bp.mispredict !== 1'b1) begin
         errors++;
         $display("FAIL jump_mis got=%b exp=1", bp.mispredict);
      end
      step();
      idle();
      #1;
      checks++;
      if (bp.predTaken !== 1'b0) begin
         errors++;
         $display("FAIL jump_pred got=%b exp=0", bp.predTaken);
      end
      checks++;
      if (bp.branchCount !== 16'd8 || bp.mispredCount !== 16'd3) begin
         errors++;
         $display("FAIL jump_cnt got=%0d/%0d exp=8/3", bp.branchCount, bp.mispredCount);
      end
   endtask

   task automatic test_same_cycle();
      logic exp_fwd;
`ifdef BP_BYPASS_EN
      exp_fwd = 1'b1;
`else
      exp_fwd = 1'b0;
`endif
      bp.fetchPC = 32'h10;
      resolve(32'h10, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (bp.predTaken !== exp_fwd) begin
         errors++;
         $display("FAIL same_cycle_pred got=%b exp=%b", bp.predTaken, exp_fwd);
      end
      step();
      idle();
      #1;
      checks++;
      if (bp.predTaken !== 1'b1) begin
         errors++;
         $display("FAIL same_cycle_after got=%b exp=1", bp.predTaken);
      end
   endtask

   task automatic test_alias();
      for (int k = 0; k < 2; k++) begin
         resolve(32'h44, 1'b0, 1'b0, 1'b1);
         step();
      end
      idle();
      bp.fetchPC = 32'h04;
      #1;
      checks++;
      if (bp.predTaken !== 1'b1) begin
         errors++;
         $display("FAIL alias_pred got=%b exp=1", bp.predTaken);
      end
      checks++;
      if (bp.branchCount !== 16'd11 || bp.mispredCount !== 16'd6) begin
         errors++;
         $display("FAIL alias_cnt got=%0d/%0d exp=11/6", bp.branchCount, bp.mispredCount);
      end
   endtask

   task automatic test_reset_resolve();
      rst = 1'b1;
      resolve(32'h08, 1'b0, 1'b0, 1'b1);
      step();
      rst = 1'b0;
      idle();
      for (int i = 0; i < 16; i++) begin
         bp.fetchPC = 32'(i * 4);
         #1;
         checks++;
         if (bp.predTaken !== 1'b0) begin
            errors++;
            $display("FAIL rst_upd_pred pc=%h got=%b exp=0", bp.fetchPC, bp.predTaken);
         end
      end
      checks++;
      if (bp.branchCount !== 16'd0 || bp.mispredCount !== 16'd0) begin
         errors++;
         $display("FAIL rst_upd_cnt got=%0d/%0d exp=0/0", bp.branchCount, bp.mispredCount);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      idle();
      bp.fetchPC = '0;
      test_reset();
      test_train();
      test_saturate();
      test_jump();
      test_same_cycle();
      test_alias();
      test_reset_resolve();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
